// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types for the register-file access controller.
// Holds the command opcodes, the controller state encoding and the
// register count of the 8x8 register file it drives.
package regfile_pkg;

    localparam int REG_COUNT = 8;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_DUMP  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    // ST_VERIFY is only entered when REGFILE_CTRL_VERIFY_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_VERIFY    = 3'd2,
        ST_READ      = 3'd3,
        ST_RESP      = 3'd4,
        ST_DUMP_RD   = 3'd5,
        ST_DUMP_RESP = 3'd6,
        ST_CLEAR     = 3'd7
    } state_t;

endpackage

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: command-driven initiator for the 8x8 register file.
// Turns write / read / dump / clear-all commands into register-file
// cycles and returns results on a response channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1. The sender holds valid and its payload stable until that
// edge; ready may depend on state but never on valid. cmd_ready is high
// only in IDLE (and not while clr is asserted); rsp_* stay frozen while
// rsp_valid is high and rsp_ready is low.
//
// Optional feature: define REGFILE_CTRL_VERIFY_EN to add a read-back
// VERIFY cycle after every write (rsp_data = read-back, rsp_err = 1 on
// mismatch). Without it rsp_err is tied 0 and writes echo their data.
module regfile_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              busy,
    output logic              rf_en,
    output logic [ADDR_W-1:0] rf_wsel,
    output logic [DATA_W-1:0] rf_d,
    output logic [ADDR_W-1:0] rf_rsel,
    input  logic [DATA_W-1:0] rf_q
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_COUNT - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

`ifdef REGFILE_CTRL_VERIFY_EN
    logic rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Commands are taken only from IDLE; clr blocks acceptance in the same cycle.
    assign cmd_ready = (state == ST_IDLE) && !clr;
    assign busy      = (state != ST_IDLE);

    // Controller FSM with all register-file and response outputs registered.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            rf_en     <= 1'b0;
            rf_wsel   <= '0;
            rf_d      <= '0;
            rf_rsel   <= '0;
`ifdef REGFILE_CTRL_VERIFY_EN
            rsp_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // clr is low here, so cmd_valid alone means accept.
                    if (cmd_valid) begin
                        addr_q <= cmd_addr;
                        data_q <= cmd_data;
                        case (op_t'(cmd_op))
                            OP_WRITE: begin
                                rf_en   <= 1'b1;
                                rf_wsel <= cmd_addr;
                                rf_d    <= cmd_data;
                                state   <= ST_WRITE;
                            end
                            OP_READ: begin
                                rf_rsel <= cmd_addr;
                                state   <= ST_READ;
                            end
                            OP_DUMP: begin
                                rf_rsel <= '0;
                                state   <= ST_DUMP_RD;
                            end
                            OP_CLEAR: begin
                                rf_en   <= 1'b1;
                                rf_wsel <= '0;
                                rf_d    <= '0;
                                state   <= ST_CLEAR;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end

                ST_WRITE: begin
                    // The register file takes the write at the end of this cycle.
                    rf_en   <= 1'b0;
                    rf_wsel <= '0;
                    rf_d    <= '0;
`ifdef REGFILE_CTRL_VERIFY_EN
                    rf_rsel <= addr_q;
                    state   <= ST_VERIFY;
`else
                    rsp_valid <= 1'b1;
                    rsp_addr  <= addr_q;
                    rsp_data  <= data_q;
                    rsp_last  <= 1'b1;
                    state     <= ST_RESP;
`endif
                end

`ifdef REGFILE_CTRL_VERIFY_EN
                ST_VERIFY: begin
                    // rf_q now reflects the freshly written register.
                    rsp_valid <= 1'b1;
                    rsp_addr  <= addr_q;
                    rsp_data  <= rf_q;
                    rsp_last  <= 1'b1;
                    rsp_err_q <= (rf_q != data_q);
                    state     <= ST_RESP;
                end
`endif

                ST_READ: begin
                    rsp_valid <= 1'b1;
                    rsp_addr  <= addr_q;
                    rsp_data  <= rf_q;
                    rsp_last  <= 1'b1;
                    state     <= ST_RESP;
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_addr  <= '0;
                        rsp_data  <= '0;
                        rsp_last  <= 1'b0;
`ifdef REGFILE_CTRL_VERIFY_EN
                        rsp_err_q <= 1'b0;
`endif
                        state     <= ST_IDLE;
                    end
                end

                ST_DUMP_RD: begin
                    rsp_valid <= 1'b1;
                    rsp_addr  <= rf_rsel;
                    rsp_data  <= rf_q;
                    rsp_last  <= (rf_rsel == LAST_ADDR);
                    state     <= ST_DUMP_RESP;
                end

                ST_DUMP_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_addr  <= '0;
                        rsp_data  <= '0;
                        rsp_last  <= 1'b0;
                        // rf_rsel stops at the last register instead of wrapping.
                        if (rsp_last) begin
                            state <= ST_IDLE;
                        end else begin
                            rf_rsel <= rf_rsel + ADDR_W'(1);
                            state   <= ST_DUMP_RD;
                        end
                    end
                end

                ST_CLEAR: begin
                    if (rf_wsel == LAST_ADDR) begin
                        rf_en     <= 1'b0;
                        rf_wsel   <= '0;
                        rf_d      <= '0;
                        rsp_valid <= 1'b1;
                        rsp_addr  <= LAST_ADDR;
                        rsp_data  <= '0;
                        rsp_last  <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        rf_wsel <= rf_wsel + ADDR_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: directed bench for regfile_ctrl with a behavioural
// 8x8 register file attached. Table-driven write/read vectors plus
// hand-written dump, clear-all and mid-operation clr sequences.
// Builds with or without REGFILE_CTRL_VERIFY_EN.
`timescale 1ns/1ps
module tb_regfile_ctrl;
    import regfile_pkg::*;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
`ifdef REGFILE_CTRL_VERIFY_EN
    localparam int WLAT = 3;
`else
    localparam int WLAT = 2;
`endif

    logic              clk;
    logic              clr;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_err;
    logic              busy;
    logic              rf_en;
    logic [ADDR_W-1:0] rf_wsel;
    logic [DATA_W-1:0] rf_d;
    logic [ADDR_W-1:0] rf_rsel;
    logic [DATA_W-1:0] rf_q;

    regfile_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .clr(clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .busy(busy),
        .rf_en(rf_en), .rf_wsel(rf_wsel), .rf_d(rf_d),
        .rf_rsel(rf_rsel), .rf_q(rf_q)
    );

    // ---------------- clock / register file model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic              rf_init;
    logic              force_en;
    logic [DATA_W-1:0] force_val;
    logic [DATA_W-1:0] rf_mem [REG_COUNT];
    int                cyc;

    assign rf_q = force_en ? force_val : rf_mem[rf_rsel];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_init) begin
            for (int i = 0; i < REG_COUNT; i++) rf_mem[i] <= '0;
        end else if (rf_en) begin
            rf_mem[rf_wsel] <= rf_d;
        end
    end

    // write-port monitor: pulse count and (cycle, wsel) log
    int                en_cnt;
    int                wlog_cyc[$];
    logic [ADDR_W-1:0] wlog_sel[$];

    always @(negedge clk) begin
        if (rf_en) begin
            en_cnt = en_cnt + 1;
            wlog_cyc.push_back(cyc);
            wlog_sel.push_back(rf_wsel);
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec;
    int n_bad;
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                lat;
        logic [DATA_W-1:0] exp_data;
        logic              exp_err;
    } vec_t;

    vec_t vecs[6];

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data);
        chk("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_data  = '0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_cmd_ready", cmd_ready, 1);
    endtask

    task automatic run_single(input vec_t v);
        int en0;
        int lat;
        en0 = en_cnt;
        send_cmd(v.op, v.addr, v.data);
        if (v.op == OP_WRITE) begin
            chk("wr_rf_en", rf_en, 1);
            chk("wr_rf_wsel", rf_wsel, v.addr);
            chk("wr_rf_d", rf_d, v.data);
            chk("wr_early_valid", rsp_valid, 0);
        end else begin
            chk("rd_rf_en", rf_en, 0);
            chk("rd_rf_rsel", rf_rsel, v.addr);
        end
        wait_rsp(lat);
        chk("latency", lat, v.lat);
        chk("rsp_data", rsp_data, v.exp_data);
        chk("rsp_addr", rsp_addr, v.addr);
        chk("rsp_last", rsp_last, 1);
        chk("rsp_err", rsp_err, v.exp_err);
        // one stalled cycle: response must hold
        @(negedge clk);
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, v.exp_data);
        finish_rsp();
        chk("en_pulses", en_cnt - en0, (v.op == OP_WRITE) ? 1 : 0);
    endtask

    // Expected dump data must already be in exp_q.
    task automatic run_dump(input bit toggle);
        int got;
        int c;
        int last_c;
        bit seen;
        send_cmd(OP_DUMP, '0, '0);
        c = 1; got = 0; seen = 1'b0; last_c = 0;
        while (got < 8 && c < 200) begin
            if (rsp_valid) begin
                if (!seen) begin
                    chk("dump_data", rsp_data, exp_q[0]);
                    chk("dump_addr", rsp_addr, got);
                    chk("dump_last", rsp_last, (got == 7) ? 1 : 0);
                end else begin
                    chk("dump_stall_data", rsp_data, exp_q[0]);
                    chk("dump_stall_addr", rsp_addr, got);
                end
                if (toggle && !seen) begin
                    rsp_ready = 1'b0;
                    seen = 1'b1;
                end else begin
                    rsp_ready = 1'b1;
                    void'(exp_q.pop_front());
                    got++;
                    seen = 1'b0;
                    last_c = c;
                end
            end else begin
                rsp_ready = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        rsp_ready = 1'b0;
        chk("dump_count", got, 8);
        if (!toggle) chk("dump_min_cycles", last_c, 16);
        chk("dump_end_busy", busy, 0);
        chk("dump_end_valid", rsp_valid, 0);
        chk("dump_end_rsel", rf_rsel, 7);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int en0;
        int lat;
        vec_t v;

        n_vec = 0; n_bad = 0; en_cnt = 0; cyc = 0;
        clr = 1'b1; rf_init = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0; force_en = 1'b0; force_val = '0;

        vecs[0] = '{OP_WRITE, 3'd0, 8'hAA, WLAT, 8'hAA, 1'b0};
        vecs[1] = '{OP_WRITE, 3'd1, 8'h55, WLAT, 8'h55, 1'b0};
        vecs[2] = '{OP_WRITE, 3'd2, 8'hFF, WLAT, 8'hFF, 1'b0};
        vecs[3] = '{OP_READ,  3'd0, 8'h00, 2,    8'hAA, 1'b0};
        vecs[4] = '{OP_READ,  3'd1, 8'h00, 2,    8'h55, 1'b0};
        vecs[5] = '{OP_READ,  3'd2, 8'h00, 2,    8'hFF, 1'b0};

        // reset
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rf_en", rf_en, 0);
        chk("rst_rf_rsel", rf_rsel, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_err", rsp_err, 0);
        clr = 1'b0; rf_init = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);

        // table: writes then reads
        for (int i = 0; i < 6; i++) run_single(vecs[i]);

        // dump with rsp_ready toggling
        exp_q = '{8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_dump(1'b1);

        // clear-all then read r0
        wlog_cyc.delete(); wlog_sel.delete();
        en0 = en_cnt;
        send_cmd(OP_CLEAR, '0, '0);
        wait_rsp(lat);
        chk("clr_latency", lat, 9);
        chk("clr_rsp_addr", rsp_addr, 7);
        chk("clr_rsp_data", rsp_data, 0);
        chk("clr_rsp_last", rsp_last, 1);
        finish_rsp();
        chk("clr_en_cnt", en_cnt - en0, 8);
        for (int i = 0; i < 8; i++) begin
            if (i < wlog_sel.size()) begin
                chk("clr_wsel", wlog_sel[i], i);
                chk("clr_consecutive", wlog_cyc[i] - wlog_cyc[0], i);
            end
        end
        v = '{OP_READ, 3'd0, 8'h00, 2, 8'h00, 1'b0};
        run_single(v);

        // refill, then interrupt a clear-all in its 4th cycle
        for (int i = 0; i < 8; i++) begin
            v = '{OP_WRITE, 3'(i), 8'(8'h10 + i), WLAT, 8'(8'h10 + i), 1'b0};
            run_single(v);
        end
        send_cmd(OP_CLEAR, '0, '0);
        repeat (3) @(negedge clk);
        chk("abort_wsel", rf_wsel, 3);
        chk("abort_en", rf_en, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rf_en", rf_en, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rf_wsel", rf_wsel, 0);

        // clr together with cmd_valid: no write to r5
        clr = 1'b1; cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 3'd5; cmd_data = 8'hEE;
        @(negedge clk);
        clr = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        chk("clrcmd_busy", busy, 0);
        chk("clrcmd_rf_en", rf_en, 0);
        @(negedge clk);
        chk("clrcmd_idle", busy, 0);

        // dump at full speed: r0..r3 cleared, r4..r7 intact
        exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h14, 8'h15, 8'h16, 8'h17};
        run_dump(1'b0);

`ifdef REGFILE_CTRL_VERIFY_EN
        // corrupted read-back must be flagged
        force_en = 1'b1; force_val = 8'h3C;
        v = '{OP_WRITE, 3'd6, 8'hCC, 3, 8'h3C, 1'b1};
        run_single(v);
        force_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Command-driven access controller that acts as the initiator for the 8×8 register file (`reg8file`). It drives the register file's write port (`en`/`wsel`/`d`) and read port (`rsel`/`q`) on behalf of an upstream master. It turns valid/ready commands (write, read, dump-all, clear-all) into correctly timed register-file cycles and returns results on a valid/ready response channel. It sits between the lab top level (switch/UART command source) and the register file instance.

## Interface
- `ADDR_W`, 3, register address width (8 registers)
- `DATA_W`, 8, register data width

- `clk`  in  1  system clock, rising edge
- `clr`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `cmd_op`  in  2  opcode: 00 write, 01 read, 10 dump, 11 clear-all
- `cmd_addr`  in  ADDR_W  target register; ignored for dump and clear-all
- `cmd_data`  in  DATA_W  write data; ignored for all other opcodes
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  downstream accepts response
- `rsp_addr`  out  ADDR_W  register the response refers to
- `rsp_data`  out  DATA_W  read data / write echo
- `rsp_last`  out  1  final response of the current command
- `rsp_err`  out  1  write verify mismatch
- `busy`  out  1  high whenever the state is not IDLE
- `rf_en`  out  1  register-file write enable
- `rf_wsel`  out  ADDR_W  register-file write address
- `rf_d`  out  DATA_W  register-file write data
- `rf_rsel`  out  ADDR_W  register-file read address, registered
- `rf_q`  in  DATA_W  register-file read data, combinational from `rf_rsel`

## Operation
- **States:** IDLE, WRITE, VERIFY (macro only), READ, RESP, DUMP_RD, DUMP_RESP, CLEAR.
- **Reset:** all outputs 0, state IDLE.
  - `cmd_ready` is 1 from the first cycle after reset, because it is combinational on IDLE.
- **Accepting commands:** `cmd_ready` = 1 only in IDLE. Accept on `cmd_valid & cmd_ready`; latch `cmd_op`, `cmd_addr` and `cmd_data`.
- **Write:**
  - IDLE → WRITE.
  - In the single WRITE cycle: `rf_en`=1, `rf_wsel`=addr, `rf_d`=data.
  - Then RESP with `rsp_data`=data, `rsp_addr`=addr, `rsp_last`=1.
- **Read:**
  - On accept, `rf_rsel`<=addr. IDLE → READ.
  - At the end of READ, capture `rf_q` into `rsp_data`. Then RESP with `rsp_last`=1.
- **Dump:**
  - On accept, `rf_rsel`<=0. Then alternate DUMP_RD (capture `rf_q`) and DUMP_RESP (wait for `rsp_ready`).
  - On each response handshake, `rf_rsel` increments.
  - Eight responses are produced, with `rsp_addr` 0..7. `rsp_last`=1 only for addr 7; no wrap past 7.
  - After the handshake on addr 7, return to IDLE.
- **Clear-all:**
  - CLEAR runs 8 consecutive cycles with `rf_en`=1, `rf_d`=0 and `rf_wsel` 0..7.
  - Then one response: `rsp_addr`=7, `rsp_data`=0, `rsp_last`=1.
- **Response holding:** RESP/DUMP_RESP hold `rsp_*` stable while `rsp_valid & !rsp_ready`. A handshake returns the block to IDLE, or to the next DUMP_RD during a dump.
- **Write-enable exclusivity:** `rf_en` is 1 only in WRITE and CLEAR. `rf_wsel` and `rf_d` return to 0 whenever `rf_en` is 0.
- **`rf_rsel` hold:** `rf_rsel` holds its last value in IDLE.
- **`rsp_err`** is 0 unless VERIFY flags a mismatch.

## Timing
- Accept at edge N. WRITE/READ occupies cycle N+1. `rsp_valid` is 1 from cycle N+2 (2-cycle latency).
  - With the verify macro, write latency is 3.
- A write updates the register file at edge N+2, coincident with `rsp_valid` rising.
- Dump: each register costs 1 read cycle plus ≥1 response cycle. The minimum is 16 cycles from accept to the last handshake.
- Clear-all: cycles N+1..N+8 write. `rsp_valid` is 1 from N+9.
- Back-to-back: the next command can be accepted in the cycle after the final response handshake, once the state is back in IDLE.
- `clr` mid-operation: at the next edge the state goes to IDLE and all outputs go to 0.
  - In-flight responses are dropped.
  - A partially completed clear-all leaves registers 0..k zeroed. The controller does not reset the register file.
- `clr` asserted together with `cmd_valid`: `clr` wins and no command is accepted.

## Configuration
- `REGFILE_CTRL_VERIFY_EN` defined:
  - After WRITE, a VERIFY cycle drives `rf_rsel`=addr and compares `rf_q` with the written data at the end of the cycle.
  - `rsp_data` = read-back value; `rsp_err` = 1 on mismatch.
  - Write latency becomes 3. Clear-all is not verified.
- Not defined: no VERIFY state, `rsp_err` tied 0, `rsp_data` echoes the write data.

## Structure
- Package `regfile_pkg` holds:
  - the opcode typedef (`OP_WRITE`, `OP_READ`, `OP_DUMP`, `OP_CLEAR`);
  - the state enum;
  - `REG_COUNT` = 8.
- Single flat module with no sub-module; the register file is instantiated beside it at the top level.

## Test plan
- Reset, then write 0xAA→r0, 0x55→r1, 0xFF→r2. Each write gives a response 2 cycles after accept with the echoed data, and `rf_en` high exactly one cycle per write.
- Read r0, r1, r2 → `rsp_data` 0xAA, 0x55, 0xFF respectively, each with `rsp_last`=1.
- Dump with `rsp_ready` toggling 1/0 → 8 responses with addr 0..7, data AA,55,FF,00,00,00,00,00, `rsp_last` only on addr 7, data stable while stalled.
- Clear-all, then read r0 → `rf_en` high for 8 consecutive cycles with `rf_wsel` 0..7, then the read returns 0x00.
- Assert `clr` during the 4th clear-all cycle → IDLE next cycle, `rf_en`=0, `rsp_valid`=0; a dump then shows r0–r3 = 00 while r4–r7 keep their prior values.
- With the macro defined, force `rf_q` wrong after a write of 0xCC → `rsp_err`=1 and `rsp_data` = the forced value, 3 cycles after accept.
